// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin sharing of one pipelined multiplier with tagged response routing
module booth_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 3,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*32-1:0] req_mcand,
  input  logic [NREQ*32-1:0] req_mplier,
  output logic [NREQ-1:0]    req_ready,
  output logic [31:0]        mul_mcand,
  output logic [31:0]        mul_mplier,
  output logic               mul_issue,
  input  logic [63:0]        mul_product,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [63:0]        rsp_product,
  output logic               busy
);
  logic [IDW-1:0]  r_ptr, r_iid, r_rsp_id;
  logic [31:0]     r_mcand, r_mplier;
  logic            r_issue;
  logic [MUL_LAT-1:0] r_tv;
  logic [IDW-1:0]  r_tid [MUL_LAT];
  logic [NREQ-1:0] r_rsp_valid;
  logic [63:0]     r_rsp_product;
  logic [IDW-1:0]  w_gid, w_ptr_nxt;
  logic [IDW:0]    w_idx;
  logic            w_found, w_hs;
  // scan from the pointer downward in priority so the nearest valid requester wins
  always_comb begin
    w_found = 1'b0;
    w_gid   = '0;
    w_idx   = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
      w_idx = (w_idx >= (IDW+1)'(NREQ)) ? w_idx - (IDW+1)'(NREQ) : w_idx;
      if (req_valid[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_gid   = w_idx[IDW-1:0];
      end
    end
  end
  assign w_hs      = w_found & ~rst;
  assign w_ptr_nxt = (w_gid == IDW'(NREQ-1)) ? '0 : w_gid + 1'b1;
  assign req_ready = w_hs ? NREQ'(1) << w_gid : '0;
  // register granted operands toward the multiplier and advance the pointer past the winner
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_issue  <= 1'b0;
      r_iid    <= '0;
    end else begin
      r_issue <= w_hs;
      if (w_hs) begin
        r_ptr    <= w_ptr_nxt;
        r_mcand  <= req_mcand[32*w_gid +: 32];
        r_mplier <= req_mplier[32*w_gid +: 32];
        r_iid    <= w_gid;
      end
    end
  end
  // tag shift pipeline matched to multiplier latency; reset drops every in-flight tag
  always_ff @(posedge clk) begin
    r_tv[0]  <= r_issue & ~rst;
    r_tid[0] <= r_iid;
    for (int s = 1; s < MUL_LAT; s++) begin
      r_tv[s]  <= r_tv[s-1] & ~rst;
      r_tid[s] <= r_tid[s-1];
    end
  end
  // capture the emerging product and route it back to its requester
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid   <= '0;
      r_rsp_id      <= '0;
      r_rsp_product <= '0;
    end else begin
      r_rsp_valid <= r_tv[MUL_LAT-1] ? NREQ'(1) << r_tid[MUL_LAT-1] : '0;
      if (r_tv[MUL_LAT-1]) begin
        r_rsp_id      <= r_tid[MUL_LAT-1];
        r_rsp_product <= mul_product;
      end
    end
  end
  assign mul_mcand   = r_mcand;
  assign mul_mplier  = r_mplier;
  assign mul_issue   = r_issue;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_product = r_rsp_product;
  assign busy        = r_issue | (|r_tv);
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb_booth_mul_arbiter: vector table plus scoreboard bench with a behavioural pipelined multiplier
module tb_booth_mul_arbiter;
  localparam int NREQ = 4, MUL_LAT = 3, IDW = 2;
  logic clk = 1'b0, rst;
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid;
  logic [NREQ*32-1:0] req_mcand, req_mplier;
  logic [31:0] mul_mcand, mul_mplier;
  logic mul_issue, busy;
  logic [63:0] mul_product, rsp_product;
  logic [IDW-1:0] rsp_id;
  typedef struct packed { logic [3:0] oh; logic [1:0] id; logic [63:0] p; int cyc; } exp_t;
  typedef struct packed { logic [3:0] v; logic [3:0] rdy; } vec_t;
  exp_t q[$];
  exp_t m;
  vec_t tbl[17];
  int n_cmp = 0, n_err = 0, cyc = 0;
  bit mon_en = 1'b0;
  logic [63:0] pipe [MUL_LAT];

  booth_mul_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_mcand(req_mcand), .req_mplier(req_mplier),
    .req_ready(req_ready), .mul_mcand(mul_mcand), .mul_mplier(mul_mplier), .mul_issue(mul_issue),
    .mul_product(mul_product), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_product(rsp_product),
    .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
    return longint'($signed(a)) * longint'($signed(b));
  endfunction
  function automatic logic [31:0] opa(input int e, input int i);
    return 32'(e*1237 - i*50021 + 3);
  endfunction
  function automatic logic [31:0] opb(input int e, input int i);
    return 32'(i*911 - e*77 + 5);
  endfunction
  function automatic logic [1:0] oh2id(input logic [3:0] oh);
    logic [1:0] r = '0;
    for (int i = 0; i < NREQ; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  always @(posedge clk) begin
    pipe[0] <= prod(mul_mcand, mul_mplier);
    for (int s = 1; s < MUL_LAT; s++) pipe[s] <= pipe[s-1];
  end
  assign mul_product = pipe[MUL_LAT-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rsp_valid !== '0) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rsp: got rsp_valid %b expected none", rsp_valid);
      end else begin
        m = q.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'(m.oh));
        chk("rsp_id", 64'(rsp_id), 64'(m.id));
        chk("rsp_product", rsp_product, m.p);
        chk("rsp_cycle", 64'(cyc), 64'(m.cyc));
      end
    end
  end

  task automatic apply(input logic [3:0] v, input logic [3:0] rdy, input int e, input bit push);
    logic [1:0] id;
    req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      req_mcand[32*i +: 32]  = opa(e, i);
      req_mplier[32*i +: 32] = opb(e, i);
    end
    @(negedge clk);
    chk($sformatf("ready_e%0d", e), 64'(req_ready), 64'(rdy));
    if (push && rdy != '0) begin
      id = oh2id(rdy);
      q.push_back('{rdy, id, prod(opa(e, int'(id)), opb(e, int'(id))), cyc + MUL_LAT + 2});
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl = '{'{4'b1111, 4'b0001}, '{4'b1111, 4'b0010}, '{4'b1111, 4'b0100}, '{4'b1111, 4'b1000},
            '{4'b1111, 4'b0001}, '{4'b0010, 4'b0010}, '{4'b1010, 4'b1000}, '{4'b1010, 4'b0010},
            '{4'b1010, 4'b1000}, '{4'b0000, 4'b0000}, '{4'b0100, 4'b0100}, '{4'b1001, 4'b1000},
            '{4'b1001, 4'b0001}, '{4'b0001, 4'b0001}, '{4'b0000, 4'b0000}, '{4'b1100, 4'b0100},
            '{4'b1100, 4'b1000}};
    rst = 1'b1;
    req_valid = '1;
    req_mcand = '0;
    req_mplier = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_in_rst", 64'(req_ready), 64'd0);
    chk("rst_mcand", 64'(mul_mcand), 64'd0);
    chk("rst_mplier", 64'(mul_mplier), 64'd0);
    chk("rst_issue", 64'(mul_issue), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_product", rsp_product, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
    mon_en = 1'b1;
    // single request from requester 2: 7*6
    req_valid = 4'b0100;
    req_mcand[64 +: 32] = 32'd7;
    req_mplier[64 +: 32] = 32'd6;
    @(negedge clk);
    chk("single_ready", 64'(req_ready), 64'b0100);
    q.push_back('{4'b0100, 2'd2, 64'd42, cyc + MUL_LAT + 2});
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("single_issue", 64'(mul_issue), 64'd1);
    chk("single_mcand", 64'(mul_mcand), 64'd7);
    chk("single_mplier", 64'(mul_mplier), 64'd6);
    chk("single_busy", 64'(busy), 64'd1);
    drain();
    @(negedge clk);
    chk("single_busy_end", 64'(busy), 64'd0);
    // pointer now 3; reset returns it to 0 before the table
    do_reset();
    for (int e = 0; e < 17; e++) apply(tbl[e].v, tbl[e].rdy, e, 1'b1);
    req_valid = '0;
    drain();
    // reset while three operations are in flight
    for (int e = 30; e < 33; e++) apply(4'b0111, 4'b0001 << (e - 30), e, 1'b0);
    req_valid = '0;
    @(negedge clk);
    chk("flight_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_rsp", 64'(rsp_valid), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    apply(4'b1111, 4'b0001, 50, 1'b1);
    req_valid = '0;
    drain();
    // idle: operands hold the last issued pair
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_issue", 64'(mul_issue), 64'd0);
      chk("idle_mcand", 64'(mul_mcand), 64'(opa(50, 0)));
      chk("idle_mplier", 64'(mul_mplier), 64'(opb(50, 0)));
    end
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_queue", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
